// File: rtl/adder_pkg.sv
// Shared constants and elaboration helper for the chunked pipelined adder/subtractor.
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Pipeline depth; returns 0 when WIDTH is not a whole number of chunks so the top can reject it.
    function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
        if (chunk == 0 || (width % chunk) != 0) begin
            return 0;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One CHUNK-bit slice of the carry-chunked adder with its pipeline register.
// Holds all state when en_i is low; ovf_o is only meaningful for the MSB slice.
module adder_chunk_stage
    import adder_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [CHUNK-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int unsigned SW = CHUNK + 1;

    logic [CHUNK-1:0] sum_d;
    logic             carry_d;
    logic             ovf_d;

    logic             valid_q;
    logic [CHUNK-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;

    // Slice add; overflow uses this slice's top bit as the sign bit.
    always_comb begin
        {carry_d, sum_d} = SW'(a_i) + SW'(b_i) + SW'(carry_i);
        ovf_d            = (a_i[CHUNK-1] == b_i[CHUNK-1]) && (sum_d[CHUNK-1] != a_i[CHUNK-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/pipelined_adder_sub.sv
// Carry-chunked pipelined add/subtract with valid/ready handshake, latency WIDTH/CHUNK.
// Define PIPELINED_ADDER_SAT_EN to clamp the result to the signed limit on overflow.
module pipelined_adder_sub
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);
    localparam int unsigned LAST   = STAGES - 1;

    if (STAGES == 0) begin : g_bad_cfg
        $error("pipelined_adder_sub: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Per-stage inputs: operands skewed so stage k sees the beat that stage k-1 just finished.
    logic [WIDTH-1:0] a_src   [STAGES];
    logic [WIDTH-1:0] b_src   [STAGES];
    logic             cy_src  [STAGES];
    logic             vld_src [STAGES];

    logic [WIDTH-1:0] a_sk_q  [STAGES];
    logic [WIDTH-1:0] b_sk_q  [STAGES];
    logic [WIDTH-1:0] lo_q    [STAGES];
    logic [WIDTH-1:0] lo_full [STAGES];
    logic [WIDTH-1:0] sum_raw;

    logic [CHUNK-1:0] sl_sum  [STAGES];
    logic             sl_cy   [STAGES];
    logic             sl_vld  [STAGES];
    logic             sl_ovf  [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign b_eff   = b ^ {WIDTH{sub == MODE_SUB}};
    assign cin_eff = (sub == MODE_ADD) ? c_in : 1'b1;

    always_comb begin
        a_src[0]   = a;
        b_src[0]   = b_eff;
        cy_src[0]  = cin_eff;
        vld_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k]   = a_sk_q[k-1];
            b_src[k]   = b_sk_q[k-1];
            cy_src[k]  = sl_cy[k-1];
            vld_src[k] = sl_vld[k-1];
        end
    end

    // Completed lower slices of the beat sitting in stage k, with stage k's own slice merged in.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            lo_full[k]                  = lo_q[k];
            lo_full[k][k*CHUNK +: CHUNK] = sl_sum[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_sk_q[k] <= '0;
                b_sk_q[k] <= '0;
                lo_q[k]   <= '0;
            end
        end else if (adv) begin
            lo_q[0] <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_sk_q[k] <= a_src[k];
                b_sk_q[k] <= b_src[k];
            end
            for (int k = 1; k < STAGES; k++) begin
                lo_q[k] <= lo_full[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk_stage #(
            .CHUNK (CHUNK)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (adv),
            .valid_i (vld_src[k]),
            .a_i     (a_src[k][k*CHUNK +: CHUNK]),
            .b_i     (b_src[k][k*CHUNK +: CHUNK]),
            .carry_i (cy_src[k]),
            .valid_o (sl_vld[k]),
            .sum_o   (sl_sum[k]),
            .carry_o (sl_cy[k]),
            .ovf_o   (sl_ovf[k])
        );
    end

    assign out_valid = sl_vld[LAST];
    assign c_out     = sl_cy[LAST];
    assign ovf       = sl_ovf[LAST];
    assign sum_raw   = lo_full[LAST];

`ifdef PIPELINED_ADDER_SAT_EN
    // On overflow the raw MSB is the inverse of a's sign, so it selects the limit directly.
    assign sum = ovf ? {~sum_raw[WIDTH-1], {(WIDTH-1){sum_raw[WIDTH-1]}}} : sum_raw;
`else
    assign sum = sum_raw;
`endif

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Scoreboard bench for pipelined_adder_sub: arithmetic reference model, latency, stall and reset checks.
module tb_pipelined_adder_sub;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned STAGES = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    typedef struct {
        logic [15:0] sum;
        logic        c_out;
        logic        ovf;
        int          acc_cyc;
        int          acc_stalls;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stalls = 0;
    logic        prev_stall = 1'b0;
    logic        prev_rst = 1'b0;
    logic [15:0] prev_sum = '0;
    logic        prev_c = 1'b0;
    logic        prev_ovf = 1'b0;

    pipelined_adder_sub #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic ci, input logic sb);
        exp_t        m;
        int          sa;
        int          sbv;
        int          r;
        logic [31:0] full;
        sa  = int'($signed(av));
        sbv = int'($signed(bv));
        if (sb) begin
            full    = 32'(av) - 32'(bv);
            m.c_out = (av >= bv);
            r       = sa - sbv;
        end else begin
            full    = 32'(av) + 32'(bv) + 32'(ci);
            m.c_out = full[16];
            r       = sa + sbv + int'(ci);
        end
        m.ovf = (r > 32767) || (r < -32768);
        m.sum = full[15:0];
`ifdef PIPELINED_ADDER_SAT_EN
        if (m.ovf) m.sum = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        m.acc_cyc    = 0;
        m.acc_stalls = 0;
        return m;
    endfunction

    // Monitor: samples on the falling edge, between the bench's drive point and the next rising edge.
    always @(negedge clk) begin : mon
        exp_t e;
        logic stall_now;
        cyc++;
        if (prev_rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_c_out", 32'(c_out), 32'd0);
            chk("rst_ovf", 32'(ovf), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end
        chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        if (out_valid === 1'b1) begin
            if (prev_stall) begin
                chk("hold_sum", 32'(sum), 32'(prev_sum));
                chk("hold_c_out", 32'(c_out), 32'(prev_c));
                chk("hold_ovf", 32'(ovf), 32'(prev_ovf));
            end else if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum %0h with empty scoreboard (cycle %0d)", sum, cyc);
            end else begin
                e = sb_q[0];
                chk("sum", 32'(sum), 32'(e.sum));
                chk("c_out", 32'(c_out), 32'(e.c_out));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("latency", 32'(cyc - e.acc_cyc), 32'(STAGES + 32'(stalls - e.acc_stalls)));
            end
        end
        stall_now = out_valid && !out_ready && !rst;
        if (stall_now) stalls++;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (in_valid && in_ready) begin
                e            = model(a, b, c_in, sub);
                e.acc_cyc    = cyc;
                e.acc_stalls = stalls;
                sb_q.push_back(e);
            end
        end
        prev_stall = stall_now;
        prev_rst   = rst;
        prev_sum   = sum;
        prev_c     = c_out;
        prev_ovf   = ovf;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
        logic acc;
        acc      = 1'b0;
        a        = av;
        b        = bv;
        c_in     = ci;
        sub      = sb;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 50 cycles");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || out_valid) && t < 100) begin
            tick();
            t++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] op_a[10];
        logic [15:0] op_b[10];
        logic        op_c[10];
        logic        op_s[10];
        logic        acc;
        int          sent;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        send(16'h1009, 16'h0006, 1'b1, 1'b0);
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();

        // Back-to-back stream with the consumer stalled for three cycles.
        for (int i = 0; i < 10; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
            op_c[i] = 1'($urandom);
            op_s[i] = 1'($urandom);
        end
        sent = 0;
        for (int c = 0; c < 40 && sent < 10; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = 1'b1;
            a         = op_a[sent];
            b         = op_b[sent];
            c_in      = op_c[sent];
            sub       = op_s[sent];
            @(negedge clk);
            if (c >= 5 && c <= 7) chk("stall_in_ready", 32'(in_ready), 32'd0);
            acc = in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 32'(sent), 32'd10);
        drain();

        // Three beats in flight, then a one-cycle reset discards them.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            c_in     = 1'($urandom);
            sub      = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        send(16'h1234, 16'h0F0F, 1'b0, 1'b1);
        drain();

        // Alternating valid pattern: bubbles must come out as bubbles.
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            a        = 16'($urandom);
            b        = 16'($urandom);
            c_in     = 1'($urandom);
            sub      = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            c_in      = 1'($urandom);
            sub       = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_sub.md
Name: pipelined_adder_sub

Overview:
- Parametrised successor to the combinational 4-bit full adder.
- Adds or subtracts two WIDTH-bit operands through a carry-chunked pipeline: one CHUNK-bit slice per stage, with the carry registered between stages.
- Valid/ready handshake on both sides gives one result per cycle at full throughput.
- Sits between operand producers and accumulators/ALU consumers in the datapath.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage.
- STAGES, WIDTH/CHUNK, derived; pipeline depth and latency in cycles. Not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in; ignored when sub=1.
- sub  input  1  0 = a+b+c_in; 1 = a-b.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Arithmetic:
  - Effective B is b^{WIDTH{sub}}.
  - Effective carry-in is sub ? 1 : c_in.
  - ovf = (a[MSB]==effB[MSB]) && (sum[MSB]!=a[MSB]).
- Pipeline structure:
  - Stage k adds slice k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of the skewed operands using the carry registered from stage k-1.
  - Upper slices travel delayed alongside; completed lower slices travel forward.
- Latency: a beat accepted at edge N appears on sum/c_out/ovf with out_valid=1 after edge N+STAGES-1, i.e. exactly STAGES cycles later with no stall.
- Advance: adv = !out_valid || out_ready. All stages shift together when adv=1 and all hold when adv=0. in_ready = adv, combinational.
- Valid tracking: each stage carries a valid bit. Bubbles (in_valid=0) propagate as valid=0 and are not compressed.
- Acceptance: a beat is taken only when in_valid && in_ready. While stalled, the output holds stable: sum/c_out/ovf do not change while out_valid && !out_ready.
- Reset values: all stage valid bits 0; out_valid=0; sum=0, c_out=0, ovf=0; in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded. No partial result is ever presented.
- Simultaneous events: output handoff and input acceptance in the same cycle are legal, giving full throughput.
- Boundary cases:
  - STAGES=1 (CHUNK=WIDTH) degenerates to a single registered adder with latency 1.
  - c_in is ignored when sub=1.
  - sub and c_in travel with their beat; mode can change beat-to-beat.

Optional Feature:
- Macro: PIPELINED_ADDER_SAT_EN.
- Defined: at the final stage, if ovf=1, sum is clamped to the signed limit. a[MSB]=0 gives 0111..1; a[MSB]=1 gives 1000..0. ovf and c_out are still reported unmodified.
- Undefined: sum wraps modulo 2^WIDTH; no clamp logic is synthesised.

Decomposition:
- Shared package adder_pkg:
  - constants MODE_ADD=1'b0, MODE_SUB=1'b1
  - function computing STAGES with an elaboration check that WIDTH%CHUNK==0
- Sub-module adder_chunk_stage: CHUNK-bit full adder slice plus its pipeline register, with enable (adv), valid, and carry in/out. The top instantiates STAGES copies in a generate loop and handles skew, handshake and the saturation/overflow output.

Test Plan:
- WIDTH=16, CHUNK=4: a=0x1009, b=0x0006, c_in=1, sub=0 -> sum=0x1010, c_out=0, ovf=0, out_valid exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0. Then sub=1, a=0x0005, b=0x0007, c_in=1 -> sum=0xFFFE, c_out=0, ovf=0.
- a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1. With PIPELINED_ADDER_SAT_EN -> sum=0x7FFF, ovf=1.
- Stream 10 consecutive beats with random operands, holding out_ready low on cycles 5–7 -> in_ready low on those cycles, no beat lost or duplicated, results in order, held outputs stable.
- Fill the pipeline with 3 beats, assert rst for 1 cycle -> out_valid=0 and sum=0 the next cycle, no stale beats emerge; a new beat then arrives with normal latency.
- Alternating in_valid (1,0,1,0) -> results appear with matching bubbles, one result per valid input.
